// File: rtl/tick_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler_if
// Brief    : Request/status bundle between the game FSM and the tick scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface tick_scheduler_if #(
    parameter int LEVEL_BITS = 3,
    parameter int CD_BITS    = 2
);
    logic                  start;
    logic                  pause;
    logic                  stop;
    logic                  speed_up;
    logic                  tick;
    logic                  cd_pulse;
    logic [CD_BITS-1:0]    countdown;
    logic [LEVEL_BITS-1:0] level;
    logic                  running;
    logic                  paused;

    modport master (
        output start, pause, stop, speed_up,
        input  tick, cd_pulse, countdown, level, running, paused
    );

    modport slave (
        input  start, pause, stop, speed_up,
        output tick, cd_pulse, countdown, level, running, paused
    );
endinterface
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Brief    : SnakeWars game-tick controller: countdown, run, pause, stop.
// Revision : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int BASE_COUNTS     = 18750000,
    parameter int STEP_COUNTS     = 1250000,
    parameter int MIN_COUNTS      = 3125000,
    parameter int COUNTER_BITS    = 25,
    parameter int MAX_LEVEL       = 7,
    parameter int LEVEL_BITS      = 3,
    parameter int COUNTDOWN_STEPS = 3,
    parameter int CD_BITS         = 2
) (
    input  logic             clk,
    input  logic             rst,
    tick_scheduler_if.slave  bus
);
    localparam int WIDE = COUNTER_BITS + LEVEL_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RUN       = 2'd2,
        S_PAUSE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] ctr_q, ctr_d;
    logic [COUNTER_BITS-1:0] period_q, period_d;
    logic [LEVEL_BITS-1:0]   level_q, level_d;
    logic [CD_BITS-1:0]      countdown_q, countdown_d;
    logic                    tick_q, tick_d;
    logic                    cd_pulse_q, cd_pulse_d;
    logic                    running_q, running_d;
    logic                    paused_q, paused_d;
    logic                    cd_wrap;
    logic                    run_wrap;

    // Reduction is formed wide and compared before subtracting so it can never wrap.
    function automatic logic [COUNTER_BITS-1:0] period_of(input logic [LEVEL_BITS-1:0] lvl);
        logic [WIDE-1:0] red;
        red = WIDE'(lvl) * WIDE'(STEP_COUNTS);
        if (red > (WIDE'(BASE_COUNTS) - WIDE'(MIN_COUNTS)))
            return COUNTER_BITS'(MIN_COUNTS);
        else
            return COUNTER_BITS'(WIDE'(BASE_COUNTS) - red);
    endfunction

    assign cd_wrap  = (ctr_q == COUNTER_BITS'(BASE_COUNTS - 1));
    assign run_wrap = (ctr_q == (period_q - COUNTER_BITS'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            period_q    <= COUNTER_BITS'(BASE_COUNTS);
            level_q     <= '0;
            countdown_q <= '0;
            tick_q      <= 1'b0;
            cd_pulse_q  <= 1'b0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            period_q    <= period_d;
            level_q     <= level_d;
            countdown_q <= countdown_d;
            tick_q      <= tick_d;
            cd_pulse_q  <= cd_pulse_d;
            running_q   <= running_d;
            paused_q    <= paused_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        period_d    = period_q;
        level_d     = level_q;
        countdown_d = countdown_q;
        tick_d      = 1'b0;
        cd_pulse_d  = 1'b0;

        if (bus.stop) begin
            state_d     = S_IDLE;
            ctr_d       = '0;
            countdown_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctr_d = '0;
                    if (bus.start) begin
                        level_d     = '0;
                        countdown_d = CD_BITS'(COUNTDOWN_STEPS);
                        state_d     = S_COUNTDOWN;
                    end
                end
                S_COUNTDOWN: begin
                    if (cd_wrap) begin
                        ctr_d       = '0;
                        cd_pulse_d  = 1'b1;
                        countdown_d = countdown_q - CD_BITS'(1);
                        if (countdown_q == CD_BITS'(1)) begin
                            period_d = period_of(level_q);
                            state_d  = S_RUN;
                        end
                    end else begin
                        ctr_d = ctr_q + COUNTER_BITS'(1);
                    end
                end
                S_RUN: begin
                    // A pause request freezes ctr, except that a due tick still fires.
                    if (run_wrap) begin
                        ctr_d    = '0;
                        tick_d   = 1'b1;
                        period_d = period_of(level_q);
                    end else if (!bus.pause) begin
                        ctr_d = ctr_q + COUNTER_BITS'(1);
                    end
                    if (bus.pause)
                        state_d = S_PAUSE;
                    else if (bus.speed_up && (level_q != LEVEL_BITS'(MAX_LEVEL)))
                        level_d = level_q + LEVEL_BITS'(1);
                end
                S_PAUSE: begin
                    if (bus.pause)
                        state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d == S_RUN);
        paused_d  = (state_d == S_PAUSE);
    end

    assign bus.tick      = tick_q;
    assign bus.cd_pulse  = cd_pulse_q;
    assign bus.countdown = countdown_q;
    assign bus.level     = level_q;
    assign bus.running   = running_q;
    assign bus.paused    = paused_q;
endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_scheduler
// Brief    : Self-checking bench for tick_scheduler against a remaining-cycles model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;
    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MINC  = 4;
    localparam int MAXL  = 7;
    localparam int STEPS = 3;

    localparam int M_IDLE = 0;
    localparam int M_CD   = 1;
    localparam int M_RUN  = 2;
    localparam int M_PAUSE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    tick_scheduler_if #(.LEVEL_BITS(3), .CD_BITS(2)) bus ();

    tick_scheduler #(
        .BASE_COUNTS(BASE), .STEP_COUNTS(STEP), .MIN_COUNTS(MINC), .COUNTER_BITS(25),
        .MAX_LEVEL(MAXL), .LEVEL_BITS(3), .COUNTDOWN_STEPS(STEPS), .CD_BITS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: tracks cycles remaining in the current interval instead of a count-up.
    int m_mode = M_IDLE;
    int m_rem = 0;
    int m_cd = 0;
    int m_level = 0;
    int m_tick = 0;
    int m_cdp = 0;

    function automatic int per(input int l);
        int p;
        p = BASE - l * STEP;
        return (p < MINC) ? MINC : p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_rem = 0; m_cd = 0; m_level = 0; m_tick = 0; m_cdp = 0;
        end else begin
            m_tick = 0;
            m_cdp  = 0;
            if (bus.stop) begin
                m_mode = M_IDLE;
                m_cd   = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (bus.start) begin
                        m_mode = M_CD; m_cd = STEPS; m_rem = BASE; m_level = 0;
                    end
                    M_CD: begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_cdp = 1;
                            m_cd  = m_cd - 1;
                            m_rem = BASE;
                            if (m_cd == 0) begin
                                m_mode = M_RUN;
                                m_rem  = per(m_level);
                            end
                        end
                    end
                    M_RUN: begin
                        if (m_rem == 1) begin
                            m_tick = 1;
                            m_rem  = per(m_level);
                            if (bus.pause) m_mode = M_PAUSE;
                            else if (bus.speed_up && m_level < MAXL) m_level = m_level + 1;
                        end else if (bus.pause) begin
                            m_mode = M_PAUSE;
                        end else begin
                            m_rem = m_rem - 1;
                            if (bus.speed_up && m_level < MAXL) m_level = m_level + 1;
                        end
                    end
                    default: if (bus.pause) m_mode = M_RUN;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checks = checks + 1;
            if (int'(bus.tick) != m_tick || int'(bus.cd_pulse) != m_cdp ||
                int'(bus.countdown) != m_cd || int'(bus.level) != m_level ||
                int'(bus.running) != int'(m_mode == M_RUN) ||
                int'(bus.paused) != int'(m_mode == M_PAUSE)) begin
                failures = failures + 1;
                $display("FAIL model_cmp t=%0t actual tick=%0d cdp=%0d cd=%0d lvl=%0d run=%0d pau=%0d required tick=%0d cdp=%0d cd=%0d lvl=%0d run=%0d pau=%0d",
                         $time, bus.tick, bus.cd_pulse, bus.countdown, bus.level, bus.running, bus.paused,
                         m_tick, m_cdp, m_cd, m_level, int'(m_mode == M_RUN), int'(m_mode == M_PAUSE));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_tick(input string name, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n <= 200);
        chk(name, n, exp);
    endtask

    task automatic measure_run(input string name, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.running !== 1'b1 && n <= 200);
        chk(name, n, exp);
    endtask

    task automatic count_ticks(input string name, input int n);
        int t = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.tick === 1'b1) t++;
        end
        chk(name, t, 0);
    endtask

    task automatic p_start;    bus.start = 1'b1;    @(negedge clk); bus.start = 1'b0;    endtask
    task automatic p_stop;     bus.stop = 1'b1;     @(negedge clk); bus.stop = 1'b0;     endtask
    task automatic p_pause;    bus.pause = 1'b1;    @(negedge clk); bus.pause = 1'b0;    endtask
    task automatic p_speed;    bus.speed_up = 1'b1; @(negedge clk); bus.speed_up = 1'b0; endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.speed_up = 1'b0;
        cyc(3);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_level", int'(bus.level), 0);
        rst = 1'b1;
        cyc(2);

        // Countdown and first ticks
        p_start;
        chk("cd_load", int'(bus.countdown), 3);
        cyc(10);
        chk("cd_pulse1", int'(bus.cd_pulse), 1);
        chk("cd_val2", int'(bus.countdown), 2);
        cyc(10);
        chk("cd_val1", int'(bus.countdown), 1);
        cyc(10);
        chk("cd_val0", int'(bus.countdown), 0);
        chk("cd_run", int'(bus.running), 1);
        measure_tick("first_tick", 10);
        measure_tick("second_tick", 10);

        // Speed levels and clamping
        repeat (3) p_speed;
        chk("level3", int'(bus.level), 3);
        measure_tick("interval_kept", 7);
        measure_tick("interval_l3", 4);
        repeat (2) p_speed;
        chk("level5", int'(bus.level), 5);
        measure_tick("l5_rest", 2);
        measure_tick("l5_clamped", 4);
        repeat (3) p_speed;
        chk("level7", int'(bus.level), 7);
        measure_tick("l7_rest", 1);
        measure_tick("l7_clamped", 4);
        p_speed;
        measure_tick("l7_sat_rest", 3);
        chk("level_sat", int'(bus.level), 7);

        // Pause mid-interval
        p_stop;
        chk("stop_keeps_level", int'(bus.level), 7);
        p_start;
        chk("start_level0", int'(bus.level), 0);
        measure_run("restart_cd", 30);
        measure_tick("restart_tick", 10);
        cyc(6);
        p_pause;
        chk("paused", int'(bus.paused), 1);
        count_ticks("pause_no_tick", 50);
        chk("still_paused", int'(bus.paused), 1);
        p_pause;
        chk("resumed", int'(bus.running), 1);
        measure_tick("resume_rest", 4);

        // Pause coincident with wrap
        cyc(9);
        p_pause;
        chk("wrap_pause_tick", int'(bus.tick), 1);
        chk("wrap_pause_paused", int'(bus.paused), 1);
        count_ticks("wrap_pause_quiet", 5);
        p_pause;
        measure_tick("wrap_resume_full", 10);

        // Stop during countdown, stop with start, stop during pause
        p_stop;
        p_start;
        cyc(12);
        p_stop;
        chk("stop_cd_countdown", int'(bus.countdown), 0);
        chk("stop_cd_cdpulse", int'(bus.cd_pulse), 0);
        bus.stop = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stop_start_cd", int'(bus.countdown), 0);
        cyc(15);
        chk("start_ignored", int'(bus.countdown), 0);
        p_start;
        measure_run("cd_again", 30);
        repeat (2) p_speed;
        p_pause;
        chk("pre_stop_paused", int'(bus.paused), 1);
        p_stop;
        chk("stop_pause_paused", int'(bus.paused), 0);
        chk("stop_pause_running", int'(bus.running), 0);
        chk("stop_pause_level", int'(bus.level), 2);

        // Asynchronous reset in RUN at level 4
        p_start;
        measure_run("cd_before_rst", 30);
        repeat (4) p_speed;
        chk("level4", int'(bus.level), 4);
        cyc(3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_level", int'(bus.level), 0);
        chk("arst_running", int'(bus.running), 0);
        chk("arst_tick", int'(bus.tick), 0);
        chk("arst_countdown", int'(bus.countdown), 0);
        @(negedge clk);
        rst = 1'b1;
        count_ticks("post_rst_no_tick", 40);
        chk("post_rst_idle", int'(bus.running), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
